// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: shared constants for the GPIO controller.
//   - Bus width constants for the peripheral register window.
//   - Byte offsets of every register in the GPIO register map.
// Optional feature macro used by the controller: GPIO_IRQ_EN.
package gpio_ctrl_pkg;

  localparam int GPIO_BUS_DW = 32;  // data width of the register bus
  localparam int GPIO_ADDR_W = 8;   // default byte-address width
  localparam int GPIO_MAX_W  = 32;  // widest supported pin bank

  localparam logic [7:0] GPIO_OFF_OUT      = 8'h00;
  localparam logic [7:0] GPIO_OFF_OE       = 8'h04;
  localparam logic [7:0] GPIO_OFF_IN       = 8'h08;
  localparam logic [7:0] GPIO_OFF_SET      = 8'h0C;
  localparam logic [7:0] GPIO_OFF_CLR      = 8'h10;
  localparam logic [7:0] GPIO_OFF_TGL      = 8'h14;
  localparam logic [7:0] GPIO_OFF_IRQ_EN   = 8'h18;
  localparam logic [7:0] GPIO_OFF_IRQ_RISE = 8'h1C;
  localparam logic [7:0] GPIO_OFF_IRQ_FALL = 8'h20;
  localparam logic [7:0] GPIO_OFF_IRQ_STAT = 8'h24;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: parameterized-width two-flop synchronizer.
// Ports:
//   clk_i  - destination clock
//   rstn_i - asynchronous active-low reset, flops clear to 0
//   d_i    - asynchronous input bus
//   q_o    - synchronized output (second flop)
module gpio_sync #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped controller for a bidirectional GPIO bank.
// Ports:
//   clk_i, rstn_i     - clock, asynchronous active-low reset
//   req_i, we_i       - access strobe (one access per high cycle), 1 = write
//   addr_i, wdata_i   - byte address (bits [1:0] ignored), write data
//   rdata_o, ready_o  - read data and completion, one cycle after req_i
//   gpio_i            - asynchronous pad input
//   gpio_o, gpio_oe   - pad output value and output enable (1 = drive)
//   irq_o             - registered level interrupt, OR of IRQ_STAT
// Bus handshake: no backpressure. Every cycle with req_i = 1 is accepted and
// answered by exactly one ready_o = 1 cycle on the following cycle; rdata_o
// carries read data only in that cycle and is 0 whenever ready_o = 0.
// Macro GPIO_IRQ_EN: when defined, the edge detector, IRQ_EN/RISE/FALL/STAT
// registers and irq_o are built; otherwise those offsets read 0, ignore
// writes, and irq_o is tied low.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int GPIO_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [GPIO_BUS_DW-1:0] wdata_i,
  output logic [GPIO_BUS_DW-1:0] rdata_o,
  output logic                   ready_o,
  input  logic [GPIO_W-1:0]      gpio_i,
  output logic [GPIO_W-1:0]      gpio_o,
  output logic [GPIO_W-1:0]      gpio_oe,
  output logic                   irq_o
);

  logic [ADDR_W-1:0]      byte_addr;
  logic [GPIO_W-1:0]      wdat;
  logic                   wr;
  logic                   unused_addr;

  logic [GPIO_W-1:0]      out_q, out_d;
  logic [GPIO_W-1:0]      oe_q, oe_d;
  logic [GPIO_W-1:0]      in_sync;
  logic [GPIO_BUS_DW-1:0] rdata_q, rdata_d;
  logic                   ready_q;

  assign byte_addr   = {addr_i[ADDR_W-1:2], 2'b00};
  assign unused_addr = ^addr_i[1:0];
  assign wdat        = wdata_i[GPIO_W-1:0];
  assign wr          = req_i & we_i;

  gpio_sync #(.W(GPIO_W)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (gpio_i),
    .q_o    (in_sync)
  );

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] prev_q;
  logic [GPIO_W-1:0] irq_en_q, irq_en_d;
  logic [GPIO_W-1:0] irq_rise_q, irq_rise_d;
  logic [GPIO_W-1:0] irq_fall_q, irq_fall_d;
  logic [GPIO_W-1:0] irq_stat_q, irq_stat_d;
  logic [GPIO_W-1:0] rise, fall, event_set, stat_clr;
  logic              irq_q;

  assign rise      = in_sync & ~prev_q;
  assign fall      = ~in_sync & prev_q;
  assign event_set = irq_en_q & ((rise & irq_rise_q) | (fall & irq_fall_q));
  assign stat_clr  = (wr && byte_addr == ADDR_W'(GPIO_OFF_IRQ_STAT)) ? wdat : '0;
  // Set has priority: a new edge in the same cycle as its W1C keeps the bit.
  assign irq_stat_d = (irq_stat_q & ~stat_clr) | event_set;
`endif

  // Register write decode and SET/CLR/TGL merge.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
`ifdef GPIO_IRQ_EN
    irq_en_d   = irq_en_q;
    irq_rise_d = irq_rise_q;
    irq_fall_d = irq_fall_q;
`endif
    if (wr) begin
      case (byte_addr)
        ADDR_W'(GPIO_OFF_OUT):      out_d = wdat;
        ADDR_W'(GPIO_OFF_OE):       oe_d  = wdat;
        ADDR_W'(GPIO_OFF_SET):      out_d = out_q | wdat;
        ADDR_W'(GPIO_OFF_CLR):      out_d = out_q & ~wdat;
        ADDR_W'(GPIO_OFF_TGL):      out_d = out_q ^ wdat;
`ifdef GPIO_IRQ_EN
        ADDR_W'(GPIO_OFF_IRQ_EN):   irq_en_d   = wdat;
        ADDR_W'(GPIO_OFF_IRQ_RISE): irq_rise_d = wdat;
        ADDR_W'(GPIO_OFF_IRQ_FALL): irq_fall_d = wdat;
`endif
        default: ;
      endcase
    end
  end

  // Read mux; write-only, read-only-on-write and unmapped offsets give 0.
  always_comb begin
    rdata_d = '0;
    if (req_i && !we_i) begin
      case (byte_addr)
        ADDR_W'(GPIO_OFF_OUT):      rdata_d = GPIO_BUS_DW'(out_q);
        ADDR_W'(GPIO_OFF_OE):       rdata_d = GPIO_BUS_DW'(oe_q);
        ADDR_W'(GPIO_OFF_IN):       rdata_d = GPIO_BUS_DW'(in_sync);
`ifdef GPIO_IRQ_EN
        ADDR_W'(GPIO_OFF_IRQ_EN):   rdata_d = GPIO_BUS_DW'(irq_en_q);
        ADDR_W'(GPIO_OFF_IRQ_RISE): rdata_d = GPIO_BUS_DW'(irq_rise_q);
        ADDR_W'(GPIO_OFF_IRQ_FALL): rdata_d = GPIO_BUS_DW'(irq_fall_q);
        ADDR_W'(GPIO_OFF_IRQ_STAT): rdata_d = GPIO_BUS_DW'(irq_stat_q);
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q   <= '0;
      oe_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
      ready_q <= req_i;
    end
  end

`ifdef GPIO_IRQ_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev_q     <= '0;
      irq_en_q   <= '0;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= in_sync;
      irq_en_q   <= irq_en_d;
      irq_rise_q <= irq_rise_d;
      irq_fall_q <= irq_fall_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= |irq_stat_q;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign gpio_o  = out_q;
  assign gpio_oe = oe_q;
  assign rdata_o = rdata_q;
  assign ready_o = ready_q;

endmodule
